time_set_ctrl: RTL and testbench
================================

// Module: time_set_ctrl
// PURPOSE
//  Button-driven time-setting controller; drives the adjust side of the digital clock counter.
//  Captures the clock's current BCD time and lets the user edit hour, minute and second fields in turn.
//  While editing, holds adjust high so the clock shows and loads the edited values every cycle.
//  On commit, drops adjust so the clock resumes counting from the edited time.
// PARAMETERS
//  TIMEOUT_CYCLES  1_000_000  idle cycles in an edit state before auto-commit; 0 = never time out
//  REPEAT_DELAY    500_000    hold cycles before auto-repeat starts (TSC_AUTOREPEAT_EN only)
//  REPEAT_RATE     100_000    cycles between repeated steps (TSC_AUTOREPEAT_EN only)
// PORTS
//  clk          in   1  clock
//  reset        in   1  asynchronous, active-high reset
//  btn_mode     in   1  debounced, clk-synchronous level; rising edge = next field / enter / commit
//  btn_inc      in   1  debounced, clk-synchronous level; rising edge = +1 on current field
//  btn_dec      in   1  debounced, clk-synchronous level; rising edge = -1 on current field
//  cur_hour_tens, cur_hour_units, cur_min_tens, cur_min_units, cur_sec_tens, cur_sec_units
//               in   4 each  clock's live BCD digits
//  adjust       out  1  high in every edit state; the clock loads adjust_* each cycle while high
//  adjust_hour  out  6  binary hour, 0..23
//  adjust_min   out  6  binary minute, 0..59
//  adjust_sec   out  6  binary second, 0..59
//  edit_field   out  2  0 = none, 1 = hour, 2 = min, 3 = sec (for display blinking)
// BEHAVIOUR
//  Reset (asynchronous): state IDLE; adjust = 0; adjust_* = 0; edit_field = 0.
//    All edge-detect history and counters clear. Reset mid-edit discards the edit.
//  Edge detection: registered previous level per button.
//    An edge sampled on cycle N takes effect on outputs at N+1 (1-cycle latency).
//  FSM states: IDLE -> SET_H -> SET_M -> SET_S -> IDLE, advanced by a mode edge.
//  IDLE
//    adjust = 0; inc/dec edges are ignored.
//    On a mode edge, capture cur_* as binary: tens*10 + units.
//    A field is captured as 0 if either of its digits is > 9, if hour > 23, or if min/sec > 59.
//    Then enter SET_H; adjust = 1 from the next cycle.
//  SET_x
//    An inc edge steps the field +1 with wrap: 23 -> 0 for hour, 59 -> 0 for min/sec.
//    A dec edge steps the field -1 with wrap: 0 -> 23 for hour, 0 -> 59 for min/sec.
//    Only the selected field changes.
//  SET_S
//    A mode edge commits: go to IDLE; adjust = 0 on the next cycle.
//    adjust_* keep their last values.
//  Simultaneous edges
//    inc + dec together: no change.
//    mode with inc/dec: mode wins and the step is dropped.
//  Timeout (TIMEOUT_CYCLES > 0)
//    The inactivity counter resets on any button edge and on entering SET_H.
//    Reaching TIMEOUT_CYCLES in any SET state goes to IDLE, committing current values (same as a mode commit).
//  edit_field tracks the state: IDLE = 0, SET_H = 1, SET_M = 2, SET_S = 3.
//  Arithmetic: hour/min/sec registers are 6-bit unsigned; capture multiply is by the constant 10.
// CONFIGURATION
//  TSC_AUTOREPEAT_EN defined
//    inc or dec held (level high, without the other) for REPEAT_DELAY cycles produces a step.
//    Further steps follow every REPEAT_RATE cycles while held.
//    Each repeated step also clears the timeout counter.
//    Releasing the button, or a mode edge, clears the repeat counter.
//  TSC_AUTOREPEAT_EN undefined
//    Only rising edges step; REPEAT_* are unused; no repeat counter is built.
// STRUCTURE
//  Package time_set_pkg:
//    state enum {IDLE, SET_H, SET_M, SET_S}
//    field codes
//    MAX_HOUR = 23, MAX_MS = 59
//    function bcd2bin(tens, units) returning 6 bits, with range check
//  Sub-module wrap_updown_cnt #(MAX):
//    6-bit load / inc / dec with wrap, 0..MAX
//    instantiated three times (hour MAX = 23, min/sec MAX = 59)
// TESTING
//  1 cur = 12:34:56; mode edge -> next cycle adjust = 1, adjust_hour = 12, adjust_min = 34, adjust_sec = 56, edit_field = 1.
//  2 SET_H with hour = 23, inc edge -> hour = 0; then dec edge -> 23. Repeat in SET_M: 59 -> 0 -> 59. Other fields unchanged.
//  3 mode x3 from IDLE, with one inc in SET_S at 56 -> 57 -> third mode edge; next cycle adjust = 0, edit_field = 0, adjust_sec = 57.
//  4 inc and dec rising on the same cycle in SET_M at 30 -> min stays 30. mode + inc on the same cycle in SET_H -> edit_field = 2, hour unchanged.
//  5 TIMEOUT_CYCLES = 16, enter SET_H, no buttons -> adjust drops exactly 16 cycles after entry. Then assert reset mid-edit -> all outputs 0 immediately.
//  6 TSC_AUTOREPEAT_EN, REPEAT_DELAY = 8, REPEAT_RATE = 4, hold inc 20 cycles in SET_S from 0 -> 1 (edge), then steps at hold cycles 8, 12, 16, 20 -> 5.
//    Without the macro the same stimulus gives 1.

Source files
------------

// File: rtl/time_set_pkg.sv
// Shared types and helpers for the time-setting controller.
//   state_t   : edit FSM states (encoding equals the edit_field code)
//   FIELD_*   : edit_field codes for display blinking
//   MAX_HOUR / MAX_MS : wrap limits for hour and minute/second fields
//   bcd2bin   : BCD digit pair to 6-bit binary, 0 when out of range
package time_set_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2,
        SET_S = 2'd3
    } state_t;

    localparam logic [1:0] FIELD_NONE = 2'd0;
    localparam logic [1:0] FIELD_HOUR = 2'd1;
    localparam logic [1:0] FIELD_MIN  = 2'd2;
    localparam logic [1:0] FIELD_SEC  = 2'd3;

    localparam logic [5:0] MAX_HOUR = 6'd23;
    localparam logic [5:0] MAX_MS   = 6'd59;

    // A corrupt digit or an out-of-range value yields 0 so editing always
    // starts from a legal time.
    function automatic logic [5:0] bcd2bin(input logic [3:0] tens,
                                           input logic [3:0] units,
                                           input logic [5:0] max_val);
        logic [6:0] v;
        v = 7'(tens) * 7'd10 + 7'(units);
        if (tens > 4'd9 || units > 4'd9 || v > {1'b0, max_val})
            return 6'd0;
        return v[5:0];
    endfunction

endpackage

// File: rtl/time_set_ctrl_wrap_cnt.sv
// wrap_updown_cnt: 6-bit field register with load and +/-1 wrap in 0..MAX.
// Ports:
//   clk, reset   clock, asynchronous active-high reset (value -> 0)
//   load         load load_val (highest priority)
//   load_val     value to load
//   inc, dec     step +1 / -1 with wrap; both together = hold
//   value        current field value
module wrap_updown_cnt #(
    parameter logic [5:0] MAX = 6'd59
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [5:0] load_val,
    input  logic       inc,
    input  logic       dec,
    output logic [5:0] value
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            value <= 6'd0;
        else if (load)
            value <= load_val;
        else if (inc && !dec)
            value <= (value >= MAX) ? 6'd0 : value + 6'd1;
        else if (dec && !inc)
            value <= (value == 6'd0 || value > MAX) ? MAX : value - 6'd1;
    end

endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: button-driven time-setting controller for the clock counter.
// Captures the live BCD time on a mode edge, then edits hour, minute and
// second in turn; adjust stays high while editing so the clock loads
// adjust_* every cycle. A mode edge in SET_S (or an inactivity timeout)
// commits by dropping adjust.
// Optional feature macro: TSC_AUTOREPEAT_EN (hold-to-repeat on inc/dec).
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   btn_mode/btn_inc/btn_dec   debounced synchronous button levels
//   cur_*_tens/units           live BCD time digits from the clock
//   adjust                     high while editing
//   adjust_hour/min/sec        binary edit values
//   edit_field                 0 none, 1 hour, 2 min, 3 sec
module time_set_ctrl
    import time_set_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter int unsigned REPEAT_DELAY   = 500_000,
    parameter int unsigned REPEAT_RATE    = 100_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic [3:0] cur_hour_tens,
    input  logic [3:0] cur_hour_units,
    input  logic [3:0] cur_min_tens,
    input  logic [3:0] cur_min_units,
    input  logic [3:0] cur_sec_tens,
    input  logic [3:0] cur_sec_units,
    output logic       adjust,
    output logic [5:0] adjust_hour,
    output logic [5:0] adjust_min,
    output logic [5:0] adjust_sec,
    output logic [1:0] edit_field
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t        state;
    logic          mode_prev, inc_prev, dec_prev;
    logic          mode_edge, inc_edge, dec_edge;
    logic          editing;
    logic          rep_fire, rep_inc, rep_dec;
    logic          inc_req, dec_req, step_inc, step_dec;
    logic          activity, timeout_hit, load;
    logic [TW-1:0] idle_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_prev <= 1'b0;
            inc_prev  <= 1'b0;
            dec_prev  <= 1'b0;
        end else begin
            mode_prev <= btn_mode;
            inc_prev  <= btn_inc;
            dec_prev  <= btn_dec;
        end
    end

    assign mode_edge = btn_mode & ~mode_prev;
    assign inc_edge  = btn_inc  & ~inc_prev;
    assign dec_edge  = btn_dec  & ~dec_prev;
    assign editing   = (state != IDLE);

`ifdef TSC_AUTOREPEAT_EN
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RW   = $clog2(RMAX + 1);

    logic [RW-1:0] rep_cnt;
    logic          rep_phase;   // 0: waiting out the initial delay, 1: repeating
    logic          held;

    // Exactly one of inc/dec held; a mode edge restarts the hold.
    assign held     = editing & ~mode_edge & (btn_inc ^ btn_dec);
    assign rep_fire = held & (rep_phase ? (32'(rep_cnt) == REPEAT_RATE - 1)
                                        : (32'(rep_cnt) == REPEAT_DELAY - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rep_cnt   <= '0;
            rep_phase <= 1'b0;
        end else if (!held) begin
            rep_cnt   <= '0;
            rep_phase <= 1'b0;
        end else if (rep_fire) begin
            rep_cnt   <= '0;
            rep_phase <= 1'b1;
        end else begin
            rep_cnt   <= rep_cnt + 1'b1;
        end
    end

    assign rep_inc = rep_fire & btn_inc;
    assign rep_dec = rep_fire & btn_dec;
`else
    assign rep_fire = 1'b0;
    assign rep_inc  = 1'b0;
    assign rep_dec  = 1'b0;
`endif

    // A mode edge wins over any step; inc and dec together cancel.
    assign inc_req  = editing & ~mode_edge & (inc_edge | rep_inc);
    assign dec_req  = editing & ~mode_edge & (dec_edge | rep_dec);
    assign step_inc = inc_req & ~dec_req;
    assign step_dec = dec_req & ~inc_req;
    assign load     = (state == IDLE) & mode_edge;

    assign activity    = mode_edge | inc_edge | dec_edge | rep_fire;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && editing && !activity &&
                         (32'(idle_cnt) == TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            idle_cnt <= '0;
        else if (!editing || activity)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            adjust     <= 1'b0;
            edit_field <= FIELD_NONE;
        end else begin
            case (state)
                IDLE: if (mode_edge) begin
                    state      <= SET_H;
                    adjust     <= 1'b1;
                    edit_field <= FIELD_HOUR;
                end
                SET_H: if (mode_edge) begin
                    state      <= SET_M;
                    edit_field <= FIELD_MIN;
                end else if (timeout_hit) begin
                    state      <= IDLE;
                    adjust     <= 1'b0;
                    edit_field <= FIELD_NONE;
                end
                SET_M: if (mode_edge) begin
                    state      <= SET_S;
                    edit_field <= FIELD_SEC;
                end else if (timeout_hit) begin
                    state      <= IDLE;
                    adjust     <= 1'b0;
                    edit_field <= FIELD_NONE;
                end
                default: if (mode_edge || timeout_hit) begin
                    state      <= IDLE;
                    adjust     <= 1'b0;
                    edit_field <= FIELD_NONE;
                end
            endcase
        end
    end

    wrap_updown_cnt #(.MAX(MAX_HOUR)) u_hour (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (bcd2bin(cur_hour_tens, cur_hour_units, MAX_HOUR)),
        .inc      (step_inc & (state == SET_H)),
        .dec      (step_dec & (state == SET_H)),
        .value    (adjust_hour)
    );

    wrap_updown_cnt #(.MAX(MAX_MS)) u_min (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (bcd2bin(cur_min_tens, cur_min_units, MAX_MS)),
        .inc      (step_inc & (state == SET_M)),
        .dec      (step_dec & (state == SET_M)),
        .value    (adjust_min)
    );

    wrap_updown_cnt #(.MAX(MAX_MS)) u_sec (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (bcd2bin(cur_sec_tens, cur_sec_units, MAX_MS)),
        .inc      (step_inc & (state == SET_S)),
        .dec      (step_dec & (state == SET_S)),
        .value    (adjust_sec)
    );

endmodule

// File: tb/tb_time_set_ctrl.sv
// Testbench for time_set_ctrl: directed scenarios followed by randomized
// button activity, all checked against a behavioural model of the editing
// rules (field values as integers with modulo wrap, hold length and idle
// time counted in cycles).
module tb_time_set_ctrl;

    localparam int TO = 16;
    localparam int RD = 8;
    localparam int RR = 4;

    logic       clk = 1'b0;
    logic       reset, btn_mode, btn_inc, btn_dec;
    logic [3:0] ht, hu, mt, mu, st, su;
    logic       adjust;
    logic [5:0] adjust_hour, adjust_min, adjust_sec;
    logic [1:0] edit_field;

    int n_cmp = 0;
    int n_bad = 0;

    int m_state, m_h, m_m, m_s, m_idle, m_hold;
    bit m_pm, m_pi, m_pd;

    time_set_ctrl #(
        .TIMEOUT_CYCLES (TO),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .btn_mode       (btn_mode),
        .btn_inc        (btn_inc),
        .btn_dec        (btn_dec),
        .cur_hour_tens  (ht),
        .cur_hour_units (hu),
        .cur_min_tens   (mt),
        .cur_min_units  (mu),
        .cur_sec_tens   (st),
        .cur_sec_units  (su),
        .adjust         (adjust),
        .adjust_hour    (adjust_hour),
        .adjust_min     (adjust_min),
        .adjust_sec     (adjust_sec),
        .edit_field     (edit_field)
    );

    always #5 clk = ~clk;

    function automatic int cap(int t, int u, int maxv);
        if (t > 9 || u > 9) return 0;
        if (t * 10 + u > maxv) return 0;
        return t * 10 + u;
    endfunction

    task automatic model_reset();
        m_state = 0; m_h = 0; m_m = 0; m_s = 0;
        m_idle = 0; m_hold = 0;
        m_pm = 0; m_pi = 0; m_pd = 0;
    endtask

    // One active clock edge of the reference, using the inputs now applied.
    task automatic model_clock();
        bit me, ie, de, rep, ui, ud;
        int step;
        if (reset) begin
            model_reset();
            return;
        end
        me = btn_mode && !m_pm;
        ie = btn_inc && !m_pi;
        de = btn_dec && !m_pd;
        rep = 0;
        step = 0;
`ifdef TSC_AUTOREPEAT_EN
        if (m_state != 0 && !me && (btn_inc != btn_dec)) begin
            m_hold++;
            if (m_hold >= RD && (m_hold - RD) % RR == 0) rep = 1;
        end else begin
            m_hold = 0;
        end
`endif
        if (m_state == 0) begin
            if (me) begin
                m_h = cap(ht, hu, 23);
                m_m = cap(mt, mu, 59);
                m_s = cap(st, su, 59);
                m_state = 1;
                m_idle = 0;
            end
        end else begin
            ui = ie || (rep && btn_inc);
            ud = de || (rep && btn_dec);
            if (!me && ui && !ud) step = 1;
            if (!me && ud && !ui) step = -1;
            case (m_state)
                1: m_h = (m_h + step + 24) % 24;
                2: m_m = (m_m + step + 60) % 60;
                default: m_s = (m_s + step + 60) % 60;
            endcase
            if (me) begin
                m_state = (m_state + 1) % 4;
                m_idle = 0;
            end else if (ie || de || rep) begin
                m_idle = 0;
            end else begin
                m_idle++;
                if (m_idle == TO) m_state = 0;
            end
        end
        m_pm = btn_mode;
        m_pi = btn_inc;
        m_pd = btn_dec;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_model();
        chk("adjust", adjust, m_state != 0);
        chk("edit_field", edit_field, m_state);
        chk("hour", adjust_hour, m_h);
        chk("min", adjust_min, m_m);
        chk("sec", adjust_sec, m_s);
    endtask

    task automatic tick();
        model_clock();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic set_time(input int h, input int m, input int s);
        ht = 4'(h / 10); hu = 4'(h % 10);
        mt = 4'(m / 10); mu = 4'(m % 10);
        st = 4'(s / 10); su = 4'(s % 10);
    endtask

    task automatic pulse_mode();
        btn_mode = 1'b1; tick();
        btn_mode = 1'b0; tick();
    endtask

    function automatic logic [3:0] rand_digit();
        if ($urandom_range(0, 9) == 0) return 4'($urandom_range(10, 15));
        return 4'($urandom_range(0, 9));
    endfunction

    initial begin
        int exp_rep;
        reset = 1'b1;
        btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
        set_time(0, 0, 0);
        model_reset();
        tick(); tick();
        chk("rst_adjust", adjust, 1'b0);
        chk("rst_field", edit_field, 2'd0);
        chk("rst_hour", adjust_hour, 6'd0);
        chk("rst_min", adjust_min, 6'd0);
        chk("rst_sec", adjust_sec, 6'd0);
        reset = 1'b0;
        tick();

        // Capture 12:34:56
        set_time(12, 34, 56);
        btn_mode = 1'b1; tick();
        chk("cap_adjust", adjust, 1'b1);
        chk("cap_hour", adjust_hour, 6'd12);
        chk("cap_min", adjust_min, 6'd34);
        chk("cap_sec", adjust_sec, 6'd56);
        chk("cap_field", edit_field, 2'd1);
        btn_mode = 1'b0; tick();

        // Walk to SET_S, step sec 56 -> 57, commit
        pulse_mode();
        chk("to_min_field", edit_field, 2'd2);
        pulse_mode();
        chk("to_sec_field", edit_field, 2'd3);
        btn_inc = 1'b1; tick();
        chk("sec_inc", adjust_sec, 6'd57);
        btn_inc = 1'b0; tick();
        btn_mode = 1'b1; tick();
        chk("commit_adjust", adjust, 1'b0);
        chk("commit_field", edit_field, 2'd0);
        chk("commit_sec", adjust_sec, 6'd57);
        chk("commit_hour", adjust_hour, 6'd12);
        btn_mode = 1'b0; tick();

        // Wrap in hour and minute fields
        set_time(23, 59, 30);
        pulse_mode();
        btn_inc = 1'b1; tick();
        chk("hour_wrap_up", adjust_hour, 6'd0);
        chk("hour_wrap_min_kept", adjust_min, 6'd59);
        btn_inc = 1'b0; tick();
        btn_dec = 1'b1; tick();
        chk("hour_wrap_down", adjust_hour, 6'd23);
        btn_dec = 1'b0; tick();
        pulse_mode();
        btn_inc = 1'b1; tick();
        chk("min_wrap_up", adjust_min, 6'd0);
        btn_inc = 1'b0; tick();
        btn_dec = 1'b1; tick();
        chk("min_wrap_down", adjust_min, 6'd59);
        chk("min_wrap_hour_kept", adjust_hour, 6'd23);
        chk("min_wrap_sec_kept", adjust_sec, 6'd30);
        btn_dec = 1'b0; tick();
        pulse_mode();
        pulse_mode();

        // Simultaneous edges
        set_time(7, 30, 15);
        pulse_mode();
        btn_mode = 1'b1; btn_inc = 1'b1; tick();
        chk("mode_inc_field", edit_field, 2'd2);
        chk("mode_inc_hour", adjust_hour, 6'd7);
        btn_mode = 1'b0; btn_inc = 1'b0; tick();
        btn_inc = 1'b1; btn_dec = 1'b1; tick();
        chk("inc_dec_min", adjust_min, 6'd30);
        btn_inc = 1'b0; btn_dec = 1'b0; tick();
        pulse_mode();
        pulse_mode();

        // Invalid digits capture as 0
        ht = 4'd2; hu = 4'd5; mt = 4'd3; mu = 4'd12; st = 4'd6; su = 4'd0;
        btn_mode = 1'b1; tick();
        chk("bad_hour", adjust_hour, 6'd0);
        chk("bad_min", adjust_min, 6'd0);
        chk("bad_sec", adjust_sec, 6'd0);
        btn_mode = 1'b0;

        // Timeout: adjust drops 16 cycles after entry (entry was the last tick)
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk("timeout_adjust", adjust, (i < 16) ? 1'b1 : 1'b0);
        end

        // Reset mid-edit clears everything at once
        set_time(5, 6, 7);
        pulse_mode();
        chk("pre_reset_adjust", adjust, 1'b1);
        reset = 1'b1;
        model_reset();
        #1;
        chk("mid_reset_adjust", adjust, 1'b0);
        chk("mid_reset_hour", adjust_hour, 6'd0);
        chk("mid_reset_sec", adjust_sec, 6'd0);
        chk("mid_reset_field", edit_field, 2'd0);
        tick();
        reset = 1'b0;
        tick();

        // Hold inc for 20 cycles in SET_S starting from 0
        set_time(0, 0, 0);
        pulse_mode();
        pulse_mode();
        pulse_mode();
        btn_inc = 1'b1;
        for (int i = 0; i < 20; i++) tick();
`ifdef TSC_AUTOREPEAT_EN
        exp_rep = 5;
`else
        exp_rep = 1;
`endif
        chk("hold_sec", adjust_sec, exp_rep);
        btn_inc = 1'b0; tick();

        // Randomized activity
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b1;
                model_reset();
                #1;
                check_model();
                tick();
                reset = 1'b0;
            end
            if ($urandom_range(0, 5) == 0) btn_mode = ~btn_mode;
            if ($urandom_range(0, 7) == 0) btn_inc = ~btn_inc;
            if ($urandom_range(0, 7) == 0) btn_dec = ~btn_dec;
            if ($urandom_range(0, 3) == 0) begin
                ht = rand_digit(); hu = rand_digit();
                mt = rand_digit(); mu = rand_digit();
                st = rand_digit(); su = rand_digit();
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
